// File: rtl/relu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : relu_pkg
//  Description : Shared types and constants for the ReLU backward-pass
//                controller: FSM state encoding, fp32 field constants and
//                the gate predicate used on the forward activation.
//  Revision    : 1.0 - initial release
// ============================================================================
package relu_pkg;

    // Explicit 2-bit encoding keeps the state register width fixed.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } relu_state_t;

    localparam int          FP32_SIGN_BIT = 31;
    localparam logic [31:0] FP32_ZERO     = 32'h0000_0000;

    // Gate is open only for strictly positive encodings: sign clear and a
    // non-zero magnitude field. +0.0, -0.0, negatives and sign-set NaNs all
    // close it. Positive-sign NaN/Inf encodings count as positive.
    function automatic logic relu_gate_open(input logic [31:0] value);
        return !value[FP32_SIGN_BIT] &&
               (value[FP32_SIGN_BIT-1:0] != FP32_ZERO[FP32_SIGN_BIT-1:0]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/relu_bwd_skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : relu_bwd_skid_fifo
//  Description : Synchronous first-word-fall-through FIFO. The head word,
//                empty flag and occupancy count are all driven directly from
//                flops. Simultaneous push and pop are both honoured.
//  Ports       : clk, reset      - clock, asynchronous active-high reset
//                push, push_data - write side (ignored when full, no pop)
//                pop             - consume head word (ignored when empty)
//                pop_data        - current head word
//                empty           - no words stored
//                count           - words stored, 0..DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module relu_bwd_skid_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int               PTR_W     = $clog2(DEPTH);
    localparam int               CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_FULL    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);
    localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic [WIDTH-1:0] r_head;
    logic             r_empty;
    logic             w_do_push;
    logic             w_do_pop;

    always_comb begin
        w_do_pop     = pop && !r_empty;
        // A full FIFO can still accept a word when the head leaves this cycle.
        w_do_push    = push && ((r_count != C_FULL) || w_do_pop);
        w_rd_ptr_nxt = r_rd_ptr + C_PTR_ONE;
        w_count_nxt  = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_nxt = r_count + C_ONE;
            2'b01:   w_count_nxt = r_count - C_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage needs no reset: only locations behind valid pointers are read.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_head   <= '0;
        end else begin
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            // Head register mirrors r_mem[r_rd_ptr]. On a pop the successor is
            // already in storage when at least two words are held; otherwise
            // the only candidate is the word being pushed this cycle.
            if (w_do_pop) begin
                if (r_count != C_ONE) begin
                    r_head <= r_mem[w_rd_ptr_nxt];
                end else if (w_do_push) begin
                    r_head <= push_data;
                end
            end else if (r_empty && w_do_push) begin
                r_head <= push_data;
            end
        end
    end

    assign pop_data = r_head;
    assign empty    = r_empty;
    assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/relu_backward_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : relu_backward_ctrl
//  Description : Sequences the ReLU backward pass over one buffer of fp32
//                elements: reads bottom_data[i] and top_diff[i], gates the
//                gradient on the sign/magnitude of the forward input and
//                writes bottom_diff[i] through a small skid FIFO.
//  Ports       : clk, reset                 - clock, async active-high reset
//                start, len, src_base,
//                dst_base                   - job request (sampled in IDLE)
//                busy, done                 - job status / completion pulse
//                rd_en, rd_addr             - shared read port to both buffers
//                bottom_rdata, top_rdata    - read data, 1 cycle after rd_en
//                wr_valid, wr_ready,
//                wr_addr, wr_data           - gradient write port
//  Revision    : 1.0 - initial release
// ============================================================================
module relu_backward_ctrl
    import relu_pkg::*;
#(
    parameter int          ADDR_W         = 10,
    parameter int          CNT_W          = 9,
    parameter int          FIFO_DEPTH     = 4,
    parameter logic [31:0] NEGATIVE_SLOPE = 32'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       bottom_rdata,
    input  logic [31:0]       top_rdata,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data
);

    localparam int               FC_W        = $clog2(FIFO_DEPTH) + 1;
    localparam int               OCC_W       = FC_W + 1;
    localparam logic [OCC_W-1:0] C_OCC_LIMIT = OCC_W'(FIFO_DEPTH);
    localparam logic [FC_W-1:0]  C_FC_ONE    = FC_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

    relu_state_t       r_state;
    relu_state_t       w_state_nxt;

    logic [CNT_W-1:0]  r_len;
    logic [ADDR_W-1:0] r_src_base;
    logic [ADDR_W-1:0] r_dst_base;
    logic [CNT_W-1:0]  r_rd_idx;
    logic [CNT_W-1:0]  r_wr_idx;
    logic              r_inflight;
    logic              r_done;

    logic              w_accept;
    logic              w_rd_en;
    logic              w_last_rd;
    logic              w_pop;
    logic              w_drain_exit;
    logic              w_finish;
    logic [OCC_W-1:0]  w_occupancy;
    logic [31:0]       w_gated;

    logic              w_fifo_empty;
    logic [FC_W-1:0]   w_fifo_count;
    logic [31:0]       w_fifo_head;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    always_comb begin
        // r_done still high means the previous job is in its status cycle.
        w_accept     = start && (r_state == IDLE) && !r_done;
        // Reserve FIFO space for every read in flight so the unconditional
        // push of returning data can never overflow.
        w_occupancy  = {1'b0, w_fifo_count} + OCC_W'(r_inflight);
        w_rd_en      = (r_state == RUN) && (w_occupancy < C_OCC_LIMIT);
        w_last_rd    = w_rd_en && (r_rd_idx == (r_len - C_CNT_ONE));
        w_pop        = !w_fifo_empty && wr_ready;
        // The last write handshake may be the one happening right now.
        w_drain_exit = !r_inflight &&
                       (w_fifo_empty || ((w_fifo_count == C_FC_ONE) && w_pop));
        // A zero-length job completes in DONE itself, so its pulse lands one
        // cycle after DONE is entered; a normal job pulses as DONE is entered.
        w_finish     = ((r_state == DRAIN) && w_drain_exit) ||
                       ((r_state == DONE) && (r_len == '0));
        w_gated      = relu_gate_open(bottom_rdata) ? top_rdata : NEGATIVE_SLOPE;
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_last_rd) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_drain_exit) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        rd_en    = w_rd_en;
        rd_addr  = r_src_base + ADDR_W'(r_rd_idx);
        busy     = (r_state != IDLE) || r_done;
        done     = r_done;
        wr_valid = !w_fifo_empty;
        wr_addr  = r_dst_base + ADDR_W'(r_wr_idx);
        wr_data  = w_fifo_head;
    end

    // ------------------------------------------------------------------
    // Job registers, index counters and read-in-flight flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_len      <= '0;
            r_src_base <= '0;
            r_dst_base <= '0;
            r_rd_idx   <= '0;
            r_wr_idx   <= '0;
            r_inflight <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            r_done     <= w_finish;
            if (w_accept) begin
                r_len      <= len;
                r_src_base <= src_base;
                r_dst_base <= dst_base;
                r_rd_idx   <= '0;
                r_wr_idx   <= '0;
            end else begin
                if (w_rd_en) begin
                    r_rd_idx <= r_rd_idx + C_CNT_ONE;
                end
                if (w_pop) begin
                    r_wr_idx <= r_wr_idx + C_CNT_ONE;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output skid FIFO: gated data enters one cycle after each read
    // ------------------------------------------------------------------
    relu_bwd_skid_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_skid_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (r_inflight),
        .push_data (w_gated),
        .pop       (w_pop),
        .pop_data  (w_fifo_head),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_relu_backward_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_relu_backward_ctrl
//  Description : Scoreboard bench for relu_backward_ctrl. Stimulus pushes the
//                hand-computed expected writes into a queue; a monitor pops
//                and compares on every write handshake and records timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_relu_backward_ctrl;

    localparam int ADDR_W = 10;
    localparam int CNT_W  = 9;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  len = '0;
    logic [ADDR_W-1:0] src_base = '0;
    logic [ADDR_W-1:0] dst_base = '0;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       bottom_rdata;
    logic [31:0]       top_rdata;
    logic              wr_valid;
    logic              wr_ready = 1'b1;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    relu_backward_ctrl #(
        .ADDR_W         (ADDR_W),
        .CNT_W          (CNT_W),
        .FIFO_DEPTH     (DEPTH),
        .NEGATIVE_SLOPE (32'h0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .len          (len),
        .src_base     (src_base),
        .dst_base     (dst_base),
        .busy         (busy),
        .done         (done),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .bottom_rdata (bottom_rdata),
        .top_rdata    (top_rdata),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data)
    );

    always #5 clk = ~clk;

    // Single-port buffers with one-cycle read latency.
    logic [31:0] bottom_mem [0:1023];
    logic [31:0] top_mem    [0:1023];
    always @(posedge clk) begin
        if (rd_en) begin
            bottom_rdata <= bottom_mem[rd_addr];
            top_rdata    <= top_mem[rd_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    logic [ADDR_W+31:0] exp_q [$];

    // Per-transfer observations (relative cycle 0 = start sampled).
    int  start_cyc = 0;
    int  first_rd, first_wv, done_cyc, busy_first, busy_last;
    int  rd_cnt, hs_cnt, wv_cnt, done_cnt, over_viol, stab_viol;
    bit  done_seen;
    bit  prev_stall = 1'b0;
    logic [ADDR_W-1:0] prev_addr;
    logic [31:0]       prev_data;
    logic [ADDR_W-1:0] rd_log [0:31];

    always @(negedge clk) begin
        int rel;
        logic [ADDR_W+31:0] exp_w;
        rel = cyc - start_cyc;
        if (!reset) begin
            if (rd_en) begin
                // Reads issued minus writes accepted = FIFO count + in-flight.
                if (rd_cnt - hs_cnt >= DEPTH) over_viol++;
                if (first_rd < 0) first_rd = rel;
                if (rd_cnt < 32) rd_log[rd_cnt] = rd_addr;
                rd_cnt++;
            end
            if (prev_stall && !(wr_valid && wr_addr == prev_addr && wr_data == prev_data))
                stab_viol++;
            prev_stall = wr_valid && !wr_ready;
            prev_addr  = wr_addr;
            prev_data  = wr_data;
            if (wr_valid) begin
                wv_cnt++;
                if (first_wv < 0) first_wv = rel;
            end
            if (wr_valid && wr_ready) begin
                hs_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got addr=0x%0h data=0x%0h, required no write",
                             wr_addr, wr_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({wr_addr, wr_data} !== exp_w) begin
                        errors++;
                        $display("FAIL sb_write: got addr=0x%0h data=0x%0h, required addr=0x%0h data=0x%0h",
                                 wr_addr, wr_data, exp_w[ADDR_W+31:32], exp_w[31:0]);
                    end
                end
            end
            if (done) begin
                if (!done_seen) done_cyc = rel;
                done_seen = 1'b1;
                done_cnt++;
            end
            if (busy) begin
                if (busy_first < 0) busy_first = rel;
                busy_last = rel;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input int addr, input logic [31:0] data);
        exp_q.push_back({ADDR_W'(addr), data});
    endtask

    task automatic do_start(input int n, input int src, input int dst);
        @(posedge clk); #1;
        start_cyc  = cyc;
        first_rd   = -1; first_wv  = -1; done_cyc = -1;
        busy_first = -1; busy_last = -1;
        rd_cnt = 0; hs_cnt = 0; wv_cnt = 0; done_cnt = 0;
        over_viol = 0; stab_viol = 0; done_seen = 1'b0;
        start    = 1'b1;
        len      = CNT_W'(n);
        src_base = ADDR_W'(src);
        dst_base = ADDR_W'(dst);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // mode 0: wr_ready held high; mode 1: one cycle high, two cycles low.
    task automatic wait_done(input int mode);
        for (int k = 0; k < 400 && !done_seen; k++) begin
            @(posedge clk); #1;
            wr_ready = (mode == 1) ? (k % 3 == 0) : 1'b1;
        end
        checks++;
        if (!done_seen) begin
            errors++;
            $display("FAIL done_timeout: got no done pulse, required one within 400 cycles");
        end
        wr_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 1024; i++) begin
            bottom_mem[i] = 32'h0;
            top_mem[i]    = 32'h0;
        end

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {busy, done, rd_en, rd_addr, wr_valid, wr_addr, wr_data}, 64'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // ---------------- 1: basic len=8 ----------------
        for (int i = 0; i < 8; i++) begin
            bottom_mem[i] = (i % 2 == 0) ? 32'h3F80_0000 : 32'hBF80_0000;
            top_mem[i]    = 32'h4000_0000;
            push_exp(32'h100 + i, (i % 2 == 0) ? 32'h4000_0000 : 32'h0);
        end
        do_start(8, 'h000, 'h100);
        wait_done(0);
        chk("t1_first_rd_cycle", first_rd, 1);
        chk("t1_first_wvalid_cycle", first_wv, 3);
        chk("t1_done_cycle", done_cyc, 11);
        chk("t1_done_pulses", done_cnt, 1);
        chk("t1_busy_first", busy_first, 1);
        chk("t1_busy_last", busy_last, 11);
        chk("t1_rd_addr_last", rd_log[7], 7);
        chk("t1_writes", hs_cnt, 8);
        chk("t1_sb_empty", exp_q.size(), 0);

        // ---------------- 2: gate edges ----------------
        bottom_mem['h10] = 32'h0000_0000;
        bottom_mem['h11] = 32'h8000_0000;
        bottom_mem['h12] = 32'h0000_0001;
        bottom_mem['h13] = 32'hFFC0_0000;
        for (int i = 0; i < 4; i++) top_mem['h10 + i] = 32'h3F80_0000;
        push_exp('h180, 32'h0);
        push_exp('h181, 32'h0);
        push_exp('h182, 32'h3F80_0000);
        push_exp('h183, 32'h0);
        do_start(4, 'h10, 'h180);
        wait_done(0);
        chk("t2_writes", hs_cnt, 4);
        chk("t2_sb_empty", exp_q.size(), 0);

        // ---------------- 3: back-pressure ----------------
        for (int i = 0; i < 16; i++) begin
            bottom_mem['h20 + i] = (i % 2 == 0) ? 32'h3F80_0000 : 32'hC000_0000;
            top_mem['h20 + i]    = 32'h1000_0000 + i;
            push_exp('h1C0 + i, (i % 2 == 0) ? (32'h1000_0000 + i) : 32'h0);
        end
        do_start(16, 'h20, 'h1C0);
        wait_done(1);
        chk("t3_writes", hs_cnt, 16);
        chk("t3_sb_empty", exp_q.size(), 0);
        chk("t3_overissue", over_viol, 0);
        chk("t3_stall_stability", stab_viol, 0);

        // ---------------- 4: len=0 and start during busy ----------------
        do_start(0, 'h30, 'h1E0);
        start    = 1'b1;          // cycle 1: must be ignored
        len      = CNT_W'(5);
        src_base = ADDR_W'('h30);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(0);
        repeat (6) @(posedge clk);
        #1;
        chk("t4_no_reads", rd_cnt, 0);
        chk("t4_no_wvalid", wv_cnt, 0);
        chk("t4_done_cycle", done_cyc, 2);
        chk("t4_done_pulses", done_cnt, 1);
        chk("t4_busy_last", busy_last, 2);

        // ---------------- 5: read address wrap ----------------
        bottom_mem['h3FE] = 32'h3F80_0000; top_mem['h3FE] = 32'h1111_1111;
        bottom_mem['h3FF] = 32'hBF80_0000; top_mem['h3FF] = 32'h2222_2222;
        push_exp('h200, 32'h1111_1111);
        push_exp('h201, 32'h0);
        push_exp('h202, 32'h4000_0000);
        push_exp('h203, 32'h0);
        do_start(4, 'h3FE, 'h200);
        wait_done(0);
        chk("t5_rd_addr0", rd_log[0], 'h3FE);
        chk("t5_rd_addr1", rd_log[1], 'h3FF);
        chk("t5_rd_addr2", rd_log[2], 'h000);
        chk("t5_rd_addr3", rd_log[3], 'h001);
        chk("t5_sb_empty", exp_q.size(), 0);

        // ---------------- 6: reset abort, then clean transfer ----------------
        for (int i = 0; i < 8; i++) begin
            bottom_mem['h40 + i] = 32'h0080_0000;
            top_mem['h40 + i]    = 32'h5000_0000 + i;
            push_exp('h300 + i, 32'h5000_0000 + i);
        end
        do_start(8, 'h40, 'h300);
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk); #1;
            if (hs_cnt == 3) found = 1'b1;
        end
        chk("t6_third_write_seen", found, 1);
        reset = 1'b1;
        #1;
        chk("t6_abort_outputs", {busy, done, rd_en, rd_addr, wr_valid, wr_addr, wr_data}, 64'h0);
        exp_q.delete();
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("t6_no_done_after_abort", done_cnt, 0);

        bottom_mem['h50] = 32'h3F80_0000; top_mem['h50] = 32'hA5A5_0000;
        bottom_mem['h51] = 32'h3F80_0000; top_mem['h51] = 32'hA5A5_0001;
        push_exp('h3F0, 32'hA5A5_0000);
        push_exp('h3F1, 32'hA5A5_0001);
        do_start(2, 'h50, 'h3F0);
        wait_done(0);
        chk("t6_clean_writes", hs_cnt, 2);
        chk("t6_clean_done_cycle", done_cyc, 5);
        chk("t6_sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
